// File: rtl/mac_quantizer.sv
// Rounds and saturates a MAC accumulator word to a signed Q-format output.
// The result is buffered in a 2-entry FIFO, together with saturation statistics.
module mac_quantizer #(
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf_sticky,
    output logic [7:0]           sat_count
);

    // One guard bit means adding the rounding constant can never wrap.
    localparam int RW = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] ROUND_ONE =
        {{(RW-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [RW-1:0]  rounded;
    logic signed [RW-1:0]  shifted;
    logic [OUT_WIDTH-1:0]  q_data;
    logic                  q_sat;

    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    logic [OUT_WIDTH-1:0]  mem_data [2];
    logic                  mem_sat  [2];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rounded = $signed({acc_in[ACC_WIDTH-1], acc_in}) + ROUND_ONE;
        shifted = rounded >>> FRAC_SHIFT;
        q_data  = shifted[OUT_WIDTH-1:0];
        q_sat   = 1'b0;
        if (shifted > SAT_MAX) begin
            q_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            q_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            q_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            q_sat  = 1'b1;
        end
    end

    // in_ready depends only on registered count and clr, never on out_ready.
    assign in_ready  = (count != 2'd2) && !clr;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is never reset; outputs are gated to zero while empty so they stay X-free.
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_sat   = out_valid ? mem_sat[rd_ptr]  : 1'b0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            ovf_sticky <= 1'b0;
            sat_count  <= 8'd0;
        end else if (clr) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            ovf_sticky <= 1'b0;
            sat_count  <= 8'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && q_sat) begin
                ovf_sticky <= 1'b1;
                if (sat_count != 8'hFF) sat_count <= sat_count + 8'd1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= q_data;
            mem_sat[wr_ptr]  <= q_sat;
        end
    end

endmodule

// File: tb/tb_mac_quantizer.sv
// Directed self-checking bench for mac_quantizer: rounding, saturation,
// FIFO backpressure, saturation counter/clear and asynchronous reset.
module tb_mac_quantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [39:0] acc_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        ovf_sticky;
    logic [7:0]  sat_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mac_quantizer #(.ACC_WIDTH(40), .OUT_WIDTH(16), .FRAC_SHIFT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .acc_in     (acc_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf_sticky (ovf_sticky),
        .sat_count  (sat_count)
    );

    // Drive inputs and sample outputs on the falling edge, away from the active edge.
    task automatic quantize_one(input logic [39:0] acc, input logic [15:0] exp_data,
                                input logic exp_sat, input string name);
        @(negedge clk);
        acc_in   = acc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL %s out_valid got=%b exp=1", name, out_valid); else passes++;
        checks++; if (out_data !== exp_data) $display("FAIL %s out_data got=%h exp=%h", name, out_data, exp_data); else passes++;
        checks++; if (out_sat !== exp_sat) $display("FAIL %s out_sat got=%b exp=%b", name, out_sat, exp_sat); else passes++;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; acc_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0000) $display("FAIL reset out_data got=%h exp=0000", out_data); else passes++;
        checks++; if (out_sat !== 1'b0) $display("FAIL reset out_sat got=%b exp=0", out_sat); else passes++;
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL reset ovf_sticky got=%b exp=0", ovf_sticky); else passes++;
        checks++; if (sat_count !== 8'd0) $display("FAIL reset sat_count got=%0d exp=0", sat_count); else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got=%b exp=1", in_ready); else passes++;
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        quantize_one(40'h00_0000_4000, 16'h0001, 1'b0, "round_half_up");
        quantize_one(40'h00_0000_3FFF, 16'h0000, 1'b0, "round_below_half");
        quantize_one(40'h00_0000_8000, 16'h0001, 1'b0, "round_exact_one");
        quantize_one(40'hFF_FFFF_C000, 16'h0000, 1'b0, "round_neg_half");
        quantize_one(40'hFF_FFFF_BFFF, 16'hFFFF, 1'b0, "round_neg_below_half");
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL rounding ovf_sticky got=%b exp=0", ovf_sticky); else passes++;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        quantize_one(40'h00_4000_0000, 16'h7FFF, 1'b1, "sat_pos");
        checks++; if (ovf_sticky !== 1'b1) $display("FAIL sat_pos ovf_sticky got=%b exp=1", ovf_sticky); else passes++;
        checks++; if (sat_count !== 8'd1) $display("FAIL sat_pos sat_count got=%0d exp=1", sat_count); else passes++;
        quantize_one(40'hFF_C000_0000, 16'h8000, 1'b0, "min_exact");
        checks++; if (sat_count !== 8'd1) $display("FAIL min_exact sat_count got=%0d exp=1", sat_count); else passes++;
        quantize_one(40'hFF_BFFF_8000, 16'h8000, 1'b1, "sat_neg");
        quantize_one(40'h00_3FFF_BFFF, 16'h7FFF, 1'b0, "max_exact");
        quantize_one(40'h7F_FFFF_FFFF, 16'h7FFF, 1'b1, "sat_acc_max");
        quantize_one(40'h80_0000_0000, 16'h8000, 1'b1, "sat_acc_min");
        checks++; if (sat_count !== 8'd4) $display("FAIL saturation sat_count got=%0d exp=4", sat_count); else passes++;
    endtask

    task automatic test_back_to_back();
        pulse_clr();
        out_ready = 1'b0;
        @(negedge clk);
        acc_in = 40'd1 << 15; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_first in_ready got=%b exp=1", in_ready); else passes++;
        @(negedge clk);
        acc_in = 40'd2 << 15;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_second in_ready got=%b exp=1", in_ready); else passes++;
        @(negedge clk);
        acc_in = 40'd3 << 15;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_full in_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (out_data !== 16'd1) $display("FAIL bp_head out_data got=%h exp=0001", out_data); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold in_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (out_data !== 16'd1) $display("FAIL bp_hold out_data got=%h exp=0001", out_data); else passes++;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 16'd2) $display("FAIL bp_pop2 out_data got=%h exp=0002", out_data); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_pop2 in_ready got=%b exp=1", in_ready); else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_pop3 out_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (out_data !== 16'd3) $display("FAIL bp_pop3 out_data got=%h exp=0003", out_data); else passes++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained out_valid got=%b exp=0", out_valid); else passes++;
    endtask

    task automatic test_sat_count_clr();
        pulse_clr();
        checks++; if (sat_count !== 8'd0) $display("FAIL clr_start sat_count got=%0d exp=0", sat_count); else passes++;
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL clr_start ovf_sticky got=%b exp=0", ovf_sticky); else passes++;
        out_ready = 1'b1;
        acc_in    = 40'h00_4000_0000;
        in_valid  = 1'b1;
        repeat (254) @(negedge clk);
        checks++; if (sat_count !== 8'd254) $display("FAIL satcnt_254 sat_count got=%0d exp=254", sat_count); else passes++;
        @(negedge clk);
        checks++; if (sat_count !== 8'd255) $display("FAIL satcnt_255 sat_count got=%0d exp=255", sat_count); else passes++;
        repeat (45) @(negedge clk);
        checks++; if (sat_count !== 8'd255) $display("FAIL satcnt_hold sat_count got=%0d exp=255", sat_count); else passes++;
        checks++; if (ovf_sticky !== 1'b1) $display("FAIL satcnt_hold ovf_sticky got=%b exp=1", ovf_sticky); else passes++;
        clr = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL clr_blocks in_ready got=%b exp=0", in_ready); else passes++;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        checks++; if (sat_count !== 8'd0) $display("FAIL clr sat_count got=%0d exp=0", sat_count); else passes++;
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL clr ovf_sticky got=%b exp=0", ovf_sticky); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL clr out_valid got=%b exp=0", out_valid); else passes++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(negedge clk);
        acc_in = 40'h00_4000_0000; in_valid = 1'b1;
        @(negedge clk);
        acc_in = 40'd5 << 15;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) $display("FAIL pre_rst in_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (ovf_sticky !== 1'b1) $display("FAIL pre_rst ovf_sticky got=%b exp=1", ovf_sticky); else passes++;
        out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL async_rst out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0000) $display("FAIL async_rst out_data got=%h exp=0000", out_data); else passes++;
        checks++; if (out_sat !== 1'b0) $display("FAIL async_rst out_sat got=%b exp=0", out_sat); else passes++;
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL async_rst ovf_sticky got=%b exp=0", ovf_sticky); else passes++;
        checks++; if (sat_count !== 8'd0) $display("FAIL async_rst sat_count got=%0d exp=0", sat_count); else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL post_rst in_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL post_rst out_valid got=%b exp=0", out_valid); else passes++;
        quantize_one(40'd7 << 15, 16'd7, 1'b0, "post_rst_word");
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_sat_count_clr();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mac_quantizer.md
MAC_QUANTIZER -- requirements
Module: mac_quantizer

Interface
REQ-001 Parameter ACC_WIDTH, default 40: width of the accumulator word consumed from the MAC stage.
REQ-002 Parameter OUT_WIDTH, default 16: width of the quantized signed output word.
REQ-003 Parameter FRAC_SHIFT, default 15: number of LSBs dropped (Q15 product scaling).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-low (rst=0 resets); released synchronously by the system.
REQ-006 Port clr  input  1  synchronous flush of FIFO, sticky flag and counter.
REQ-007 Port acc_in  input  ACC_WIDTH  signed two's-complement accumulator value from the MAC.
REQ-008 Port in_valid  input  1  acc_in holds a result to quantize.
REQ-009 Port in_ready  output  1  block can accept acc_in this cycle.
REQ-010 Port out_data  output  OUT_WIDTH  quantized signed word at FIFO head.
REQ-011 Port out_sat  output  1  out_data was saturated.
REQ-012 Port out_valid  output  1  FIFO head is valid.
REQ-013 Port out_ready  input  1  consumer takes head this cycle.
REQ-014 Port ovf_sticky  output  1  set once any accepted word saturated.
REQ-015 Port sat_count  output  8  count of saturated words, saturating at 255.

Function
REQ-016 Accept (push) occurs when in_valid=1 and in_ready=1; pop occurs when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be 0 when FIFO holds 2 entries or clr=1, else 1; purely from registered state and clr, no combinational path from out_ready.
REQ-018 Rounding: r = acc_in + 2^(FRAC_SHIFT-1), computed at ACC_WIDTH+1 bits sign-extended (no wrap), then arithmetic shift right FRAC_SHIFT (round half toward +inf).
REQ-019 Saturation: r > 2^(OUT_WIDTH-1)-1 gives 0x7FFF with sat=1; r < -2^(OUT_WIDTH-1) gives 0x8000 with sat=1; otherwise low OUT_WIDTH bits, sat=0.
REQ-020 Quantized word and sat bit written into a 2-entry FIFO on accept; latency accept-edge to out_valid=1 is 1 cycle when FIFO empty.
REQ-021 FIFO: read/write pointers 1 bit each wrap 1->0; count 0..2; out_valid = (count != 0); out_data/out_sat driven from read-pointer entry.
REQ-022 Simultaneous push and pop with count=1: count stays 1, new word becomes head next cycle; with count=2 push is blocked (in_ready=0) even if popping.
REQ-023 Pop with count=0 impossible (out_valid=0); out_ready ignored when out_valid=0.
REQ-024 ovf_sticky set on the cycle after any accepted word with sat=1; cleared only by reset or clr.
REQ-025 sat_count increments by 1 per accepted saturated word; holds at 255, never wraps.
REQ-026 clr=1: next cycle count=0, pointers=0, ovf_sticky=0, sat_count=0; any push in that cycle is blocked; clr has priority over pop.
REQ-027 FIFO contents not reset; out_data don't-care while out_valid=0 but SHALL be X-free after first write.

Reset
REQ-028 rst=0 asynchronously forces: count=0, pointers=0, out_valid=0, in_ready=1 (after release, clr=0), ovf_sticky=0, sat_count=0, out_data=0, out_sat=0.
REQ-029 Reset asserted mid-transfer discards all stored words; no pop is signalled in that cycle.

Verification
REQ-030 acc_in=40'h00_0000_4000, in_valid pulse, out_ready=1 -> one cycle later out_valid=1, out_data=16'h0001, out_sat=0; acc_in=40'h00_0000_3FFF -> out_data=16'h0000.
REQ-031 acc_in=40'h00_4000_0000 -> out_data=16'h7FFF, out_sat=1, ovf_sticky=1, sat_count=1; acc_in=40'hFF_C000_0000 -> out_data=16'h8000, out_sat=0.
REQ-032 acc_in=40'hFF_BFFF_8000 (-2^30-2^15) -> out_data=16'h8000, out_sat=1.
REQ-033 out_ready=0, push 3 words (1,2,3 in Q15 ints) -> in_ready=0 after second accept, third held; raise out_ready -> pops 1,2 then 3 in order, no loss or duplicate.
REQ-034 300 saturating words -> sat_count stops at 255; then clr pulse -> sat_count=0, ovf_sticky=0, out_valid=0 next cycle.
REQ-035 rst=0 asserted asynchronously between clock edges with count=2 -> out_valid=0 immediately, all status outputs 0.
